// File: rtl/opb_cnt_seq_ctrl.sv
// OPB slave sequencer that resets, runs and stops a test counter datapath.
// Optional done interrupt and mask bit: define OPB_CNT_SEQ_CTRL_IRQ_EN.
module opb_cnt_seq_ctrl #(
  parameter logic [31:0] C_BASEADDR = 32'h01010300,
  parameter logic [31:0] C_HIGHADDR = 32'h010103FF,
  parameter int unsigned RST_LEN    = 4
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [0:31] OPB_ABus,
  input  logic [0:31] OPB_DBus,
  input  logic [0:3]  OPB_BE,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic        cnt_rst,
  output logic        cnt_en
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
  ,
  output logic        done_irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] period_q, period_d;
  logic        cont_q, cont_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        mask_q, mask_d;

  // Bus vectors are big-endian; re-view them as numeric [31:0] values.
  logic [31:0] abus;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [1:0]  offset;
  logic        hit, xfer, wr, rd;
  logic        ctrl_wr, period_wr, start, abort;
  logic [31:0] rdata;
  logic        unused_seq;

  assign abus       = OPB_ABus;
  assign wdata      = OPB_DBus;
  assign be         = OPB_BE;
  assign offset     = abus[3:2];
  assign unused_seq = OPB_seqAddr;

  assign hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign xfer      = ack_q && hit;
  assign wr        = xfer && !OPB_RNW;
  assign rd        = xfer && OPB_RNW;
  assign ctrl_wr   = wr && (offset == 2'd0);
  assign period_wr = wr && (offset == 2'd1);
  assign start     = ctrl_wr && be[0] && wdata[0];
  assign abort     = ctrl_wr && be[0] && wdata[2];

  always_comb begin
    ack_d    = hit && !ack_q;
    period_d = period_q;
    cont_d   = cont_q;
    mask_d   = mask_q;
    for (int j = 0; j < 4; j++) begin
      if (period_wr && be[j]) period_d[8*j +: 8] = wdata[8*j +: 8];
    end
    if (ctrl_wr && be[0]) begin
      cont_d = wdata[1];
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
      mask_d = wdata[3];
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    count_d   = count_q;
    done_d    = done_q && !ctrl_wr;
    if (state_q == ST_DONE) done_d = 1'b1;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d   = ST_RST;
            rst_cnt_d = 8'd0;
          end
        end
        ST_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            count_d = 32'd0;
            state_d = (period_q == 32'd0) ? ST_DONE : ST_RUN;
          end else begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end
        end
        // A PERIOD already at or below count runs on until the counter wraps.
        ST_RUN: begin
          if (count_q == period_q - 32'd1) state_d = ST_DONE;
          else count_d = count_q + 32'd1;
        end
        ST_DONE: begin
          if (cont_q) begin
            state_d   = ST_RST;
            rst_cnt_d = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = 32'h0;
    unique case (offset)
      2'd0: rdata = {30'h0, cont_q, 1'b0};
      2'd1: rdata = period_q;
      2'd2: rdata = {28'h0, mask_q, done_q, state_q};
      2'd3: rdata = count_q;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= 8'd0;
      count_q   <= 32'd0;
      period_q  <= 32'd0;
      cont_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      mask_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      count_q   <= count_d;
      period_q  <= period_d;
      cont_q    <= cont_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      mask_q    <= mask_d;
    end
  end

  assign Sl_DBus    = rd ? rdata : 32'h0;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign cnt_rst    = (state_q == ST_RST);
  assign cnt_en     = (state_q == ST_RUN);
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
  assign done_irq   = (state_q == ST_DONE) && !mask_q;
`endif

endmodule

// File: tb/tb_opb_cnt_seq_ctrl.sv
// Bench for opb_cnt_seq_ctrl: directed vector table, corner sequences and
// randomized bus traffic checked cycle by cycle against a behavioural model.
module tb_opb_cnt_seq_ctrl;
  localparam logic [31:0] BASE = 32'h01010300;
  localparam logic [31:0] HIGH = 32'h010103FF;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:31] dbus_i = '0;
  logic [0:3]  be_i = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [0:31] sl_dbus;
  logic        sl_ack, sl_err, sl_retry, sl_tout, cnt_rst, cnt_en;
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
  logic        done_irq;
`endif

  always #5 clk = ~clk;

  opb_cnt_seq_ctrl #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .RST_LEN(RL)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_DBus(dbus_i),
    .OPB_BE(be_i), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err),
    .Sl_retry(sl_retry), .Sl_toutSup(sl_tout), .cnt_rst(cnt_rst),
    .cnt_en(cnt_en)
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
    , .done_irq(done_irq)
`endif
  );

  int errors = 0;
  int checks = 0;
  int n_rst, n_en;

  // Behavioural model: phase code, remaining reset cycles, registers.
  int          m_phase = 0;
  int          m_left = 0;
  logic [31:0] m_count = '0, m_period = '0;
  logic        m_cont = 1'b0, m_done = 1'b0, m_mask = 1'b0, m_ack = 1'b0;

  typedef struct {
    logic [31:0] period;
    logic [3:0]  pbe;
    logic [31:0] ctrl;
    int          wait_n;
    int          exp_rst;
    int          exp_en;
    logic [31:0] exp_status;
    logic [31:0] exp_count;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return {30'h0, m_cont, 1'b0};
      2'd1:    return m_period;
      2'd2:    return {28'h0, m_mask, m_done, 2'(m_phase)};
      default: return m_count;
    endcase
  endfunction

  task automatic tick();
    logic [31:0] a, d, per, cnt, exp_db;
    logic hit, wr, ctrl_wr, start, abort, done_n, cont_n, mask_n;
    int ph, left;
    a = abus;
    d = dbus_i;
    hit = sel && (a >= BASE) && (a <= HIGH);
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_count = '0; m_period = '0;
      m_cont = 1'b0; m_done = 1'b0; m_mask = 1'b0; m_ack = 1'b0;
    end else begin
      wr      = m_ack && hit && !rnw;
      ctrl_wr = wr && (a[3:2] == 2'd0);
      start   = ctrl_wr && be_i[3] && d[0];
      abort   = ctrl_wr && be_i[3] && d[2];
      ph = m_phase; left = m_left; cnt = m_count; per = m_period;
      cont_n = m_cont; mask_n = m_mask;
      done_n = (m_done && !ctrl_wr) || (m_phase == 3);
      if (abort) ph = 0;
      else begin
        case (m_phase)
          0: if (start) begin ph = 1; left = RL; end
          1: begin
            left = m_left - 1;
            if (left == 0) begin cnt = '0; ph = (m_period == 0) ? 3 : 2; end
          end
          2: if (m_count == m_period - 32'd1) ph = 3; else cnt = m_count + 32'd1;
          default: if (m_cont) begin ph = 1; left = RL; end else ph = 0;
        endcase
      end
      if (wr && a[3:2] == 2'd1)
        for (int j = 0; j < 4; j++) if (be_i[3-j]) per[8*j +: 8] = d[8*j +: 8];
      if (ctrl_wr && be_i[3]) begin
        cont_n = d[1];
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
        mask_n = d[3];
`endif
      end
      m_ack = hit && !m_ack;
      m_phase = ph; m_left = left; m_count = cnt; m_period = per;
      m_cont = cont_n; m_done = done_n; m_mask = mask_n;
    end
    @(posedge clk);
    #1;
    a = abus;
    hit = sel && (a >= BASE) && (a <= HIGH);
    exp_db = (m_ack && hit && rnw) ? m_read(a[3:2]) : 32'h0;
    check("cnt_rst", 32'(cnt_rst), 32'(m_phase == 1));
    check("cnt_en", 32'(cnt_en), 32'(m_phase == 2));
    check("xfer_ack", 32'(sl_ack), 32'(m_ack));
    check("sl_dbus", sl_dbus, exp_db);
`ifdef OPB_CNT_SEQ_CTRL_IRQ_EN
    check("done_irq", 32'(done_irq), 32'(m_phase == 3 && !m_mask));
`endif
    n_rst += int'(cnt_rst);
    n_en  += int'(cnt_en);
  endtask

  task automatic bus_idle();
    sel = 1'b0; rnw = 1'b0; abus = '0; dbus_i = '0; be_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    bus_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_rst = 0;
    n_en = 0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; rnw = 1'b0; abus = BASE + {28'h0, off, 2'b00}; dbus_i = d; be_i = be;
    tick();
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] v);
    sel = 1'b1; rnw = 1'b1; abus = BASE + {28'h0, off, 2'b00}; be_i = 4'hF;
    tick();
    v = sl_dbus;
    tick();
    bus_idle();
  endtask

  initial begin
    logic [31:0] v;
    logic h_rst[24];
    logic h_en[24];
    int acks, mism, s_rst, s_en;

    vecs[0] = '{32'd5,        4'hF, 32'h1, 30,  4, 5,   32'h4, 32'd4};
    vecs[1] = '{32'd0,        4'hF, 32'h1, 20,  4, 0,   32'h4, 32'd0};
    vecs[2] = '{32'd3,        4'hF, 32'h5, 20,  0, 0,   32'h0, 32'd0};
    vecs[3] = '{32'd1,        4'hF, 32'h1, 20,  4, 1,   32'h4, 32'd0};
    vecs[4] = '{32'd7,        4'hE, 32'h1, 20,  4, 0,   32'h4, 32'd0};
    vecs[5] = '{32'hAB000102, 4'h3, 32'h1, 280, 4, 258, 32'h4, 32'h101};

    // Reset state
    do_reset();
    check("rst_cnt_rst", 32'(cnt_rst), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_ack", 32'(sl_ack), 32'd0);
    check("rst_dbus", sl_dbus, 32'd0);
    check("tied_zero", 32'({sl_err, sl_retry, sl_tout}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check("rst_reg", v, 32'd0);
    end

    foreach (vecs[k]) begin
      do_reset();
      bus_write(2'd1, vecs[k].period, vecs[k].pbe);
      bus_write(2'd0, vecs[k].ctrl, 4'hF);
      idle(vecs[k].wait_n);
      check($sformatf("vec%0d_rst_cycles", k), 32'(n_rst), 32'(vecs[k].exp_rst));
      check($sformatf("vec%0d_en_cycles", k), 32'(n_en), 32'(vecs[k].exp_en));
      bus_read(2'd2, v);
      check($sformatf("vec%0d_status", k), v, vecs[k].exp_status);
      bus_read(2'd3, v);
      check($sformatf("vec%0d_count", k), v, vecs[k].exp_count);
    end

    // Continuous mode repeats every RST_LEN + PERIOD + 1 cycles, then abort
    do_reset();
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'h3, 4'hF);
    for (int i = 0; i < 24; i++) begin
      h_rst[i] = cnt_rst;
      h_en[i] = cnt_en;
      tick();
    end
    s_rst = 0; s_en = 0; mism = 0;
    for (int i = 0; i < 8; i++) begin
      s_rst += int'(h_rst[i]);
      s_en += int'(h_en[i]);
    end
    for (int i = 0; i < 16; i++)
      if (h_rst[i] != h_rst[i+8] || h_en[i] != h_en[i+8]) mism++;
    check("cont_rst_per_loop", 32'(s_rst), 32'd4);
    check("cont_en_per_loop", 32'(s_en), 32'd3);
    check("cont_periodic", 32'(mism), 32'd0);
    bus_write(2'd0, 32'h4, 4'hF);
    check("abort_idle", 32'({cnt_rst, cnt_en}), 32'd0);
    bus_read(2'd2, v);
    check("abort_state", 32'(v[1:0]), 32'd0);

    // PERIOD shortened mid-run takes effect on the terminal compare
    do_reset();
    bus_write(2'd1, 32'd20, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    idle(10);
    bus_write(2'd1, 32'd12, 4'hF);
    idle(30);
    bus_read(2'd3, v);
    check("period_change_count", v, 32'd11);

    // Held select: ack every second cycle; out-of-window address never acked
    do_reset();
    sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h8; be_i = 4'hF;
    acks = 0;
    repeat (6) begin tick(); acks += int'(sl_ack); end
    check("held_sel_acks", 32'(acks), 32'd3);
    abus = HIGH + 32'd4;
    acks = 0;
    repeat (4) begin tick(); acks += int'(sl_ack); end
    check("outside_acks", 32'(acks), 32'd0);
    bus_idle();

    // Reset during RUN and during a transfer
    do_reset();
    bus_write(2'd1, 32'd100, 4'hF);
    bus_write(2'd0, 32'h3, 4'hF);
    idle(10);
    check("in_run", 32'(cnt_en), 32'd1);
    sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h8;
    rst_n = 1'b0;
    tick();
    check("rst_run_en", 32'(cnt_en), 32'd0);
    check("rst_drop_ack", 32'(sl_ack), 32'd0);
    bus_idle();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v);
      check("rst_run_reg", v, 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: bus_write(2'd1, 32'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
        3, 4:    bus_write(2'd0, 32'($urandom_range(0, 15)),
                           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
        5, 6, 7: bus_read(2'($urandom_range(0, 3)), v);
        8:       idle($urandom_range(1, 12));
        default: if ($urandom_range(0, 9) == 0) do_reset(); else idle(1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
